// File: rtl/test_seq_pkg.sv
// ---------------------------------------------------------------------------
// test_seq_pkg
// Shared definitions for the unit-test sequencer: default parameter values
// and the sequencer state encoding.
// ---------------------------------------------------------------------------
package test_seq_pkg;

  localparam int unsigned DEFAULT_N_TESTS     = 8;
  localparam int unsigned DEFAULT_TIMEOUT_CYC = 1024;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RELEASE,
    FINISH
  } seq_state_e;

endpackage

// File: rtl/seq_timer.sv
// ---------------------------------------------------------------------------
// seq_timer
// Loadable down-counter that saturates at zero, used as the per-slot
// watchdog of the test sequencer.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset, clears the count
//   load     - load load_val into the counter (wins over en)
//   load_val - reload value
//   en       - decrement by one this cycle (never below zero)
//   zero     - counter is at zero, or reaches zero at the end of this
//              enabled cycle
// ---------------------------------------------------------------------------
module seq_timer
  import test_seq_pkg::*;
#(
  parameter int unsigned W = $clog2(DEFAULT_TIMEOUT_CYC + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload has priority, otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flag the cycle in which the count hits zero, not the one after, so the
  // owner can react on the same edge the counter expires.
  assign zero = (cnt_q == '0) || (en && (cnt_q == W'(1)));

endmodule

// File: rtl/test_sequencer.sv
// ---------------------------------------------------------------------------
// test_sequencer
// Runs a set of unit tests one after another. Each enabled slot receives a
// one-hot start level until it raises its finish flag or its watchdog
// expires; expired slots are recorded in timeout_mask.
//
// Ports:
//   clk          - rising-edge clock
//   rst_n        - asynchronous active-low reset
//   go           - pulse that launches a run (ignored while busy)
//   enable_mask  - slots to run, sampled on go
//   finish       - level finish flags from the unit tests
//   start        - one-hot start level to the unit tests
//   busy         - a run is in progress
//   done         - one-cycle pulse when a run completes
//   timeout_mask - slots that timed out in the last run
//   cur_idx      - slot currently or last started
// ---------------------------------------------------------------------------
module test_sequencer
  import test_seq_pkg::*;
#(
  parameter int unsigned N_TESTS     = DEFAULT_N_TESTS,
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  localparam int         IDX_W       = (N_TESTS > 1) ? $clog2(N_TESTS) : 1,
  localparam int         TMR_W       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic [N_TESTS-1:0] enable_mask,
  input  logic [N_TESTS-1:0] finish,
  output logic [N_TESTS-1:0] start,
  output logic               busy,
  output logic               done,
  output logic [N_TESTS-1:0] timeout_mask,
  output logic [IDX_W-1:0]   cur_idx
);

  seq_state_e         state_q;
  logic [N_TESTS-1:0] pending_q;
  logic [N_TESTS-1:0] start_q;
  logic [N_TESTS-1:0] timeoutMask_q;
  logic [IDX_W-1:0]   curIdx_q;
  logic               busy_q;
  logic               done_q;

  logic               tmrLoad;
  logic               tmrEn;
  logic               tmrZero;
  logic [IDX_W-1:0]   firstIdx;
  logic [IDX_W-1:0]   nextIdx;

  // Priority search: index of the lowest set bit, 0 when the mask is empty.
  function automatic logic [IDX_W-1:0] lowestSet(input logic [N_TESTS-1:0] mask);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = int'(N_TESTS) - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [N_TESTS-1:0] oneHot(input logic [IDX_W-1:0] idx);
    logic [N_TESTS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // pending_q holds the latched slots not yet launched, so the next slot is
  // simply its lowest set bit.
  assign firstIdx = lowestSet(enable_mask);
  assign nextIdx  = lowestSet(pending_q);

  assign tmrLoad = (state_q == LAUNCH);
  assign tmrEn   = (state_q == WAIT);

  seq_timer #(
    .W (TMR_W)
  ) uTimer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmrLoad),
    .load_val (TMR_W'(TIMEOUT_CYC)),
    .en       (tmrEn),
    .zero     (tmrZero)
  );

  // Sequencer FSM with registered outputs. start is set on the edge that
  // enters LAUNCH and cleared on the edge that leaves WAIT, so it is high for
  // exactly the LAUNCH and WAIT cycles. A finish seen together with the timer
  // expiring counts as a clean finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      start_q       <= '0;
      timeoutMask_q <= '0;
      curIdx_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            timeoutMask_q <= '0;
            busy_q        <= 1'b1;
            pending_q     <= enable_mask;
            curIdx_q      <= firstIdx;
            if (|enable_mask) begin
              start_q <= oneHot(firstIdx);
              state_q <= LAUNCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end
          end
        end
        LAUNCH: begin
          pending_q[curIdx_q] <= 1'b0;
          state_q             <= WAIT;
        end
        WAIT: begin
          if (finish[curIdx_q]) begin
            start_q <= '0;
            state_q <= RELEASE;
          end else if (tmrZero) begin
            start_q                 <= '0;
            timeoutMask_q[curIdx_q] <= 1'b1;
            state_q                 <= RELEASE;
          end
        end
        RELEASE: begin
          if (|pending_q) begin
            curIdx_q <= nextIdx;
            start_q  <= oneHot(nextIdx);
            state_q  <= LAUNCH;
          end else begin
            done_q  <= 1'b1;
            state_q <= FINISH;
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign start        = start_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout_mask = timeoutMask_q;
  assign cur_idx      = curIdx_q;

endmodule

// File: tb/tb_test_sequencer.sv
// ---------------------------------------------------------------------------
// tb_test_sequencer
// Directed scoreboard bench for test_sequencer (8 slots, 16-cycle watchdog).
// Each scenario queues the events it expects: a start vector rising, the
// number of cycles that start stays high, and the done pulse with its
// timeout_mask / cur_idx. A monitor pops and compares whenever the DUT
// shows one of those events. A responder plays the unit tests: slot i
// raises finish once start[i] has been high for slotDelay[i] cycles
// (0 = finish held high, -1 = never finishes).
// ---------------------------------------------------------------------------
module tb_test_sequencer;

  localparam int NT = 8;
  localparam int TO = 16;

  localparam int EV_START = 0;
  localparam int EV_END   = 1;
  localparam int EV_DONE  = 2;

  typedef struct {
    int kind;
    int val;
    int idx;
  } evt_t;

  logic          clk;
  logic          rst_n;
  logic          go;
  logic [NT-1:0] enable_mask;
  logic [NT-1:0] finish;
  logic [NT-1:0] start;
  logic          busy;
  logic          done;
  logic [NT-1:0] timeout_mask;
  logic [2:0]    cur_idx;

  int   checks   = 0;
  int   failures = 0;
  evt_t expQ[$];
  int   slotDelay[NT];

  test_sequencer #(
    .N_TESTS     (NT),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .go           (go),
    .enable_mask  (enable_mask),
    .finish       (finish),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .timeout_mask (timeout_mask),
    .cur_idx      (cur_idx)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic string evName(input int kind);
    case (kind)
      EV_START: return "start vector";
      EV_END:   return "start high cycles";
      default:  return "timeout_mask at done";
    endcase
  endfunction

  task automatic scoreEvent(input int kind, input int val, input int idx);
    evt_t e;
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected %s: got %0d expected no event", evName(kind), val);
      return;
    end
    e = expQ.pop_front();
    checkOutput("event kind", kind, e.kind);
    checkOutput(evName(e.kind), val, e.val);
    if (e.idx >= 0) checkOutput("cur_idx at event", idx, e.idx);
  endtask

  task automatic expStart(input int slot);
    expQ.push_back('{EV_START, 1 << slot, slot});
  endtask

  task automatic expEnd(input int cycles);
    expQ.push_back('{EV_END, cycles, -1});
  endtask

  task automatic expDone(input int tmask, input int idx);
    expQ.push_back('{EV_DONE, tmask, idx});
  endtask

  task automatic setAllDelays(input int d);
    for (int i = 0; i < NT; i++) slotDelay[i] = d;
  endtask

  // Pulse go for one cycle, then scramble enable_mask to show it was latched.
  task automatic applyStimulus(input logic [NT-1:0] mask);
    enable_mask = mask;
    go          = 1'b1;
    @(negedge clk);
    go          = 1'b0;
    enable_mask = ~mask;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d events outstanding expected 0", expQ.size());
      expQ.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  // Unit-test model driving finish.
  initial begin : responder
    int cnt[NT];
    for (int i = 0; i < NT; i++) cnt[i] = 0;
    finish = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NT; i++) begin
        if (rst_n && start[i]) cnt[i]++;
        else cnt[i] = 0;
        finish[i] = (slotDelay[i] == 0) || (slotDelay[i] > 0 && cnt[i] >= slotDelay[i]);
      end
    end
  end

  // Monitor: turns start edges and done pulses into scoreboard events.
  initial begin : monitor
    logic [NT-1:0] prevStart;
    int            hiCnt;
    prevStart = '0;
    hiCnt     = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevStart = '0;
        hiCnt     = 0;
      end else begin
        if (start != prevStart) begin
          if (prevStart != '0) scoreEvent(EV_END, hiCnt, -1);
          if (start != '0) begin
            scoreEvent(EV_START, int'(start), int'(cur_idx));
            hiCnt = 0;
          end
        end
        if (start != '0) hiCnt++;
        if (done) scoreEvent(EV_DONE, int'(timeout_mask), int'(cur_idx));
        prevStart = start;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin : stimulus
    int n;
    rst_n       = 1'b1;
    go          = 1'b0;
    enable_mask = '0;
    setAllDelays(5);

    // Asynchronous reset before the first clock edge.
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset start", int'(start), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset timeout_mask", int'(timeout_mask), 0);
    checkOutput("reset cur_idx", int'(cur_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All slots, each finishing after 5 cycles of start.
    $display("[TB] all slots enabled");
    setAllDelays(5);
    @(negedge clk);
    for (int i = 0; i < NT; i++) begin
      expStart(i);
      expEnd(5);
    end
    expDone(0, 7);
    applyStimulus(8'hFF);
    waitDrain(200);
    checkOutput("cur_idx held after run", int'(cur_idx), 7);
    checkOutput("busy after run", int'(busy), 0);

    // Sparse mask, with a go mid-run that must be ignored.
    $display("[TB] sparse mask 0xA4");
    expStart(2); expEnd(5);
    expStart(5); expEnd(5);
    expStart(7); expEnd(5);
    expDone(0, 7);
    applyStimulus(8'hA4);
    repeat (8) @(negedge clk);
    checkOutput("busy mid-run", int'(busy), 1);
    enable_mask = 8'h01;
    go          = 1'b1;
    @(negedge clk);
    go = 1'b0;
    waitDrain(200);
    checkOutput("cur_idx after sparse run", int'(cur_idx), 7);

    // Slot 3 never finishes: 17 cycles of start, then slot 4 runs.
    $display("[TB] timeout on slot 3");
    setAllDelays(5);
    slotDelay[2] = 2;
    slotDelay[3] = -1;
    @(negedge clk);
    expStart(2); expEnd(2);
    expStart(3); expEnd(17);
    expStart(4); expEnd(5);
    expDone(8'h08, 4);
    applyStimulus(8'h1C);
    waitDrain(300);

    // Finish coinciding with expiry, one cycle too late, and already high.
    $display("[TB] finish at timer expiry");
    setAllDelays(5);
    slotDelay[0] = 17;
    slotDelay[1] = 18;
    slotDelay[2] = 0;
    @(negedge clk);
    expStart(0); expEnd(17);
    expStart(1); expEnd(17);
    expStart(2); expEnd(2);
    expDone(8'h02, 2);
    applyStimulus(8'h07);
    waitDrain(300);

    // Empty mask: done without any start; a second go while busy is ignored.
    $display("[TB] empty mask");
    setAllDelays(5);
    @(negedge clk);
    expDone(0, -1);
    enable_mask = '0;
    go          = 1'b1;
    @(negedge clk);
    checkOutput("done one cycle after go", int'(done), 1);
    checkOutput("busy during finish", int'(busy), 1);
    @(negedge clk);
    go = 1'b0;
    checkOutput("busy after empty run", int'(busy), 0);
    checkOutput("done single pulse", int'(done), 0);
    waitDrain(20);

    // Reset while slot 2 is waiting; the run must not resume.
    $display("[TB] reset mid-run");
    setAllDelays(5);
    slotDelay[2] = -1;
    @(negedge clk);
    expStart(0); expEnd(5);
    expStart(1); expEnd(5);
    expStart(2);
    applyStimulus(8'h07);
    n = 0;
    while (start != 8'h04 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("slot 2 started before reset", int'(start), 4);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset start", int'(start), 0);
    checkOutput("async reset busy", int'(busy), 0);
    checkOutput("async reset done", int'(done), 0);
    checkOutput("async reset timeout_mask", int'(timeout_mask), 0);
    checkOutput("async reset cur_idx", int'(cur_idx), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("no start after reset", int'(start), 0);
    checkOutput("idle after reset", int'(busy), 0);
    checkOutput("events outstanding after reset", expQ.size(), 0);
    expQ.delete();

    // Fresh run after reset behaves normally.
    setAllDelays(3);
    @(negedge clk);
    expStart(0); expEnd(3);
    expDone(0, 0);
    applyStimulus(8'h01);
    waitDrain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/test_sequencer.md
TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 SHALL have parameter N_TESTS, default 8: number of unit-test slots.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024: maximum cycles allowed per test from start to finish.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port go, input, 1 bit: pulse that launches a sequence run.
REQ-006 SHALL have port enable_mask, input, N_TESTS bits: bit i=1 means slot i is run; it is sampled on go.
REQ-007 SHALL have port finish, input, N_TESTS bits: finish flag from each unit test, level-sensitive.
REQ-008 SHALL have port start, output, N_TESTS bits: one-hot start level to the unit tests.
REQ-009 SHALL have port busy, output, 1 bit: a run is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when a run completes.
REQ-011 SHALL have port timeout_mask, output, N_TESTS bits: bit i=1 means slot i timed out in the last run.
REQ-012 SHALL have port cur_idx, output, clog2(N_TESTS) bits: index of the slot currently or last started.

Function
REQ-013 SHALL implement the states IDLE, LAUNCH, WAIT, RELEASE and FINISH.
REQ-014 SHALL, in IDLE, on go=1: latch enable_mask, clear timeout_mask, set busy=1, set cur_idx to the lowest enabled slot, and go to LAUNCH.
REQ-015 SHALL, on go=1 with enable_mask=0, go directly to FINISH, pulse done one cycle later, and never assert any start.
REQ-016 SHALL, in LAUNCH, hold start[cur_idx]=1 with all other start bits 0, load the timer with TIMEOUT_CYC, and go to WAIT on the next cycle.
REQ-017 SHALL, in WAIT, keep start[cur_idx]=1 and decrement the timer each cycle.
REQ-018 SHALL leave WAIT for RELEASE when finish[cur_idx]=1 is sampled.
REQ-019 SHALL, on timer reaching 0 in WAIT, set timeout_mask[cur_idx] and go to RELEASE.
REQ-020 SHALL, when finish and timeout occur in the same cycle, treat the test as finished and leave timeout_mask clear.
REQ-021 SHALL deassert all start bits in RELEASE, stay in RELEASE for exactly one cycle, then advance cur_idx to the next higher enabled slot and go to LAUNCH, or go to FINISH if no enabled slot remains.
REQ-022 SHALL, in FINISH, pulse done=1 for one cycle, clear busy, and return to IDLE; cur_idx and timeout_mask SHALL hold until the next go.
REQ-023 SHALL ignore go while busy=1.
REQ-024 SHALL ignore finish bits of non-current slots.
REQ-025 SHALL not restart a slot whose finish is already 1 at LAUNCH; that slot completes in the first WAIT cycle.
REQ-026 SHALL give a minimum per-slot latency of 3 cycles (LAUNCH, WAIT, RELEASE).
REQ-027 SHALL size the timer to clog2(TIMEOUT_CYC+1) bits and SHALL not wrap it below 0.

Reset
REQ-028 SHALL, on rst_n=0, immediately force state=IDLE, start=0, busy=0, done=0, timeout_mask=0, cur_idx=0 and timer=0, irrespective of clk.
REQ-029 SHALL, on reset asserted mid-run, drop start within the reset assertion and SHALL not resume the run after reset release.

Structure
REQ-030 SHALL place the state enumeration and the default parameter values in the shared package test_seq_pkg.
REQ-031 SHALL implement the loadable down-counter with zero flag as the sub-module seq_timer (ports clk, rst_n, load, load_val, en, zero).
REQ-032 SHALL implement the next-enabled-slot search as a combinational priority function over the latched mask.

Verification
REQ-033 SHALL verify all slots enabled, with each finish rising 5 cycles after its start -> start bits rise in order 0..7, each one-hot, done pulses once, timeout_mask=0.
REQ-034 SHALL verify enable_mask=8'b1010_0100 -> only start[2], start[5] and start[7] ever assert, and cur_idx=7 after done.
REQ-035 SHALL verify TIMEOUT_CYC=16 with finish[3] held 0 -> start[3] high for 17 cycles, timeout_mask=8'h08, and the sequence continues to slot 4.
REQ-036 SHALL verify finish rising on the same cycle the timer hits 0 -> timeout_mask bit stays 0.
REQ-037 SHALL verify rst_n pulsed low while in WAIT on slot 2 -> start=0, busy=0 asynchronously, IDLE after release, and no start until the next go.
REQ-038 SHALL verify go with enable_mask=0 -> done pulses within 2 cycles and start stays 0; a second go while busy -> ignored.
